regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 143 ++++++++++++++
 tb/tb_regfile_mp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file.
//
// Holds DEPTH registers of WIDTH bits. Register 0 always reads as zero and
// ignores writes. There are NUM_RD asynchronous read ports and two synchronous
// write ports, and every write has byte enables. When both write ports target
// the same register in one cycle, the result is merged byte by byte: port 1
// wins wherever its byte enable is set.
//
// Optional feature (macro REGFILE_MP_BYPASS_EN):
//   If defined, write data that will commit at the next edge is forwarded to
//   read ports addressing the same register in the same cycle.
//   If undefined, reads return only stored contents.
//
// Parameters:
//   WIDTH  - data bits per register (multiple of 8, 8..64)
//   DEPTH  - register count (power of 2, 2..64)
//   NUM_RD - read port count (1..4)
//
// Ports:
//   clk        - clock; all state updates on its rising edge
//   rst_n      - synchronous active-low reset; clears every register and
//                forces all rd ports to zero while low
//   ra         - packed read addresses, port k at [k*AW +: AW]
//   rd         - packed read data, port k at [k*WIDTH +: WIDTH]
//   we0/we1    - write enables
//   wa0/wa1    - write addresses
//   wd0/wd1    - write data
//   wbe0/wbe1  - byte enables; bit b covers data bits [8b+7:8b]
module regfile_mp #(
  parameter int unsigned  WIDTH  = 32,
  parameter int unsigned  DEPTH  = 32,
  parameter int unsigned  NUM_RD = 2,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned NB     = WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD*AW-1:0]    ra,
  output logic [NUM_RD*WIDTH-1:0] rd,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [AW-1:0]           wa0,
  input  logic [AW-1:0]           wa1,
  input  logic [WIDTH-1:0]        wd0,
  input  logic [WIDTH-1:0]        wd1,
  input  logic [NB-1:0]           wbe0,
  input  logic [NB-1:0]           wbe1
);

  // Elaboration-time parameter legality checks.
  if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("regfile_mp: WIDTH must be a multiple of 8 in 8..64");
  end
  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_mp: DEPTH must be a power of 2 in 2..64");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be in 1..4");
  end

  typedef logic [WIDTH-1:0] word_t;

  // Byte-wise merge of up to two writes over an old word. Port 1 has
  // priority per byte; bytes neither port enables keep the old value.
  function automatic word_t merge_bytes(input word_t         old_word,
                                        input logic          hit0,
                                        input word_t         data0,
                                        input logic [NB-1:0] be0,
                                        input logic          hit1,
                                        input word_t         data1,
                                        input logic [NB-1:0] be1);
    word_t res;
    res = old_word;
    for (int b = 0; b < NB; b++) begin
      if (hit1 && be1[b]) begin
        res[8*b +: 8] = data1[8*b +: 8];
      end else if (hit0 && be0[b]) begin
        res[8*b +: 8] = data0[8*b +: 8];
      end
    end
    return res;
  endfunction

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];

  // Writes to register 0 are dropped here, so they never reach storage or
  // the bypass path.
  logic wr0_en;
  logic wr1_en;

  always_comb begin
    wr0_en = we0 && (wa0 != '0);
    wr1_en = we1 && (wa1 != '0);
  end

  // Next-state storage. Entry 0 is held at zero permanently.
  always_comb begin
    mem_d    = mem_q;
    mem_d[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      mem_d[i] = merge_bytes(mem_q[i],
                             wr0_en && (wa0 == AW'(i)), wd0, wbe0,
                             wr1_en && (wa1 == AW'(i)), wd1, wbe1);
    end
  end

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Asynchronous read ports.
  logic [AW-1:0] rd_addr [NUM_RD];
  word_t         rd_word [NUM_RD];

  always_comb begin
    rd = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr[k] = ra[k*AW +: AW];
`ifdef REGFILE_MP_BYPASS_EN
      // Forward bytes that will commit at the next edge.
      rd_word[k] = merge_bytes(mem_q[rd_addr[k]],
                               wr0_en && (wa0 == rd_addr[k]), wd0, wbe0,
                               wr1_en && (wa1 == rd_addr[k]), wd1, wbe1);
`else
      rd_word[k] = mem_q[rd_addr[k]];
`endif
      // Reset blanks every port, and register 0 always reads zero.
      if (!rst_n || (rd_addr[k] == '0)) begin
        rd_word[k] = '0;
      end
      rd[k*WIDTH +: WIDTH] = rd_word[k];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp. It uses a default instance
// (32x32, 2 read ports) and a wide instance (64-bit, 16 deep, 4 read ports).
// Expected values are constants worked out by hand from the intended behaviour.
module tb_regfile_mp;

  localparam int unsigned AW  = 5;
  localparam int unsigned NB  = 4;
  localparam int unsigned BAW = 4;
  localparam int unsigned BNB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default instance signals.
  logic [2*AW-1:0] ra_a;
  logic [63:0]     rd_a;
  logic            we0_a, we1_a;
  logic [AW-1:0]   wa0_a, wa1_a;
  logic [31:0]     wd0_a, wd1_a;
  logic [NB-1:0]   wbe0_a, wbe1_a;

  // Wide instance signals.
  logic [4*BAW-1:0] ra_b;
  logic [255:0]     rd_b;
  logic             we0_b, we1_b;
  logic [BAW-1:0]   wa0_b, wa1_b;
  logic [63:0]      wd0_b, wd1_b;
  logic [BNB-1:0]   wbe0_b, wbe1_b;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_byp;

  regfile_mp u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ra   (ra_a),
    .rd   (rd_a),
    .we0  (we0_a),
    .we1  (we1_a),
    .wa0  (wa0_a),
    .wa1  (wa1_a),
    .wd0  (wd0_a),
    .wd1  (wd1_a),
    .wbe0 (wbe0_a),
    .wbe1 (wbe1_a)
  );

  regfile_mp #(
    .WIDTH (64),
    .DEPTH (16),
    .NUM_RD(4)
  ) u_dut_wide (
    .clk  (clk),
    .rst_n(rst_n),
    .ra   (ra_b),
    .rd   (rd_b),
    .we0  (we0_b),
    .we1  (we1_b),
    .wa0  (wa0_b),
    .wa1  (wa1_b),
    .wd0  (wd0_b),
    .wd1  (wd1_b),
    .wbe0 (wbe0_b),
    .wbe1 (wbe1_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    we0_a  = 1'b0;
    we1_a  = 1'b0;
    wbe0_a = '0;
    wbe1_a = '0;
  endtask

  // Point both read ports of the default instance at addr and check both.
  task automatic read_a(input string tag, input int addr, input logic [31:0] exp);
    logic [31:0] av;
    av = addr;
    ra_a[0 +: AW]  = av[AW-1:0];
    ra_a[AW +: AW] = av[AW-1:0];
    #1;
    check_eq({tag, "_p0"}, {32'h0, rd_a[0 +: 32]}, {32'h0, exp});
    check_eq({tag, "_p1"}, {32'h0, rd_a[32 +: 32]}, {32'h0, exp});
  endtask

  task automatic write0_a(input int addr, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] av;
    av     = addr;
    we0_a  = 1'b1;
    wa0_a  = av[AW-1:0];
    wd0_a  = data;
    wbe0_a = be;
  endtask

  initial begin
    rst_n = 1'b0;
    ra_a = '0; we0_a = 0; we1_a = 0; wa0_a = '0; wa1_a = '0;
    wd0_a = '0; wd1_a = '0; wbe0_a = '0; wbe1_a = '0;
    ra_b = '0; we0_b = 0; we1_b = 0; wa0_b = '0; wa1_b = '0;
    wd0_b = '0; wd1_b = '0; wbe0_b = '0; wbe1_b = '0;

    // Reset state.
    step();
    step();
    read_a("rst_hold_r5", 5, 32'h0);
    rst_n = 1'b1;
    read_a("after_rst_r5", 5, 32'h0);
    read_a("after_rst_r31", 31, 32'h0);

    // Register 0 protection, during the write cycle and after the edge.
    write0_a(0, 32'hDEADBEEF, 4'hF);
    read_a("r0_during_wr", 0, 32'h0);
    step();
    idle_a();
    read_a("r0_after_wr", 0, 32'h0);

    // Byte enables.
    write0_a(5, 32'h11223344, 4'hF);
    step();
    idle_a();
    read_a("r5_full", 5, 32'h11223344);
    write0_a(5, 32'hAABBCCDD, 4'b0101);
    step();
    idle_a();
    read_a("r5_partial", 5, 32'h11BB33DD);

    // Same-address collision, port 1 wins on its enabled bytes.
    write0_a(7, 32'h0000FFFF, 4'hF);
    we1_a = 1'b1; wa1_a = 5'd7; wd1_a = 32'hAAAA0000; wbe1_a = 4'b1100;
    step();
    idle_a();
    read_a("r7_collision", 7, 32'hAAAAFFFF);

    // Collision where port 1 masks some bytes and port 0 others.
    write0_a(7, 32'h11111111, 4'b0011);
    we1_a = 1'b1; wa1_a = 5'd7; wd1_a = 32'h22222222; wbe1_a = 4'b0110;
    step();
    idle_a();
    read_a("r7_coll_mix", 7, 32'hAA222211);

    // Same-cycle forwarding, depending on the build.
`ifdef REGFILE_MP_BYPASS_EN
    exp_byp = 32'h12345678;
`else
    exp_byp = 32'h0;
`endif
    write0_a(9, 32'h12345678, 4'hF);
    ra_a[0 +: AW]  = 5'd5;
    ra_a[AW +: AW] = 5'd9;
    #1;
    check_eq("bypass_p1", {32'h0, rd_a[32 +: 32]}, {32'h0, exp_byp});
    check_eq("bypass_p0_other", {32'h0, rd_a[0 +: 32]}, {32'h0, 32'h11BB33DD});
    step();
    idle_a();
    read_a("r9_after_edge", 9, 32'h12345678);

    // Two writes to different addresses in the same cycle.
    write0_a(10, 32'hCAFEF00D, 4'hF);
    we1_a = 1'b1; wa1_a = 5'd11; wd1_a = 32'h0BADBEEF; wbe1_a = 4'hF;
    step();
    idle_a();
    read_a("dual_r10", 10, 32'hCAFEF00D);
    read_a("dual_r11", 11, 32'h0BADBEEF);

    // No write happens without an enable, even if the data and byte enables are set.
    wa0_a = 5'd5; wd0_a = 32'hFFFFFFFF; wbe0_a = 4'hF; we0_a = 1'b0;
    step();
    step();
    idle_a();
    read_a("hold_r5", 5, 32'h11BB33DD);

    // Fill r1..r31 with their index, then reset while a write is in flight.
    for (int i = 1; i < 32; i++) begin
      write0_a(i, i, 4'hF);
      step();
    end
    idle_a();
    read_a("fill_r3", 3, 32'd3);
    read_a("fill_r31", 31, 32'd31);
    rst_n = 1'b0;
    we1_a = 1'b1; wa1_a = 5'd3; wd1_a = 32'hFFFFFFFF; wbe1_a = 4'hF;
    ra_a[0 +: AW]  = 5'd3;
    ra_a[AW +: AW] = 5'd31;
    #1;
    check_eq("rst_rd_p0", {32'h0, rd_a[0 +: 32]}, 64'h0);
    check_eq("rst_rd_p1", {32'h0, rd_a[32 +: 32]}, 64'h0);
    step();
    rst_n = 1'b1;
    idle_a();
    for (int i = 0; i < 32; i++) begin
      read_a($sformatf("post_rst_r%0d", i), i, 32'h0);
    end

    // Wide configuration: dual writes to r2 and r15, read on all four ports.
    we0_b = 1'b1; wa0_b = 4'd2;  wd0_b = 64'h0123456789ABCDEF; wbe0_b = 8'hFF;
    we1_b = 1'b1; wa1_b = 4'd15; wd1_b = 64'hFEDCBA9876543210; wbe1_b = 8'hFF;
    step();
    we0_b = 1'b0; we1_b = 1'b0;
    ra_b = {4'd15, 4'd2, 4'd15, 4'd2};
    #1;
    check_eq("wide_p0_r2",  rd_b[0   +: 64], 64'h0123456789ABCDEF);
    check_eq("wide_p1_r15", rd_b[64  +: 64], 64'hFEDCBA9876543210);
    check_eq("wide_p2_r2",  rd_b[128 +: 64], 64'h0123456789ABCDEF);
    check_eq("wide_p3_r15", rd_b[192 +: 64], 64'hFEDCBA9876543210);
    ra_b = {4'd2, 4'd15, 4'd2, 4'd15};
    #1;
    check_eq("wide_p0_r15", rd_b[0   +: 64], 64'hFEDCBA9876543210);
    check_eq("wide_p3_r2",  rd_b[192 +: 64], 64'h0123456789ABCDEF);

    // Wide partial write: clear the low four bytes of r15.
    we1_b = 1'b1; wa1_b = 4'd15; wd1_b = 64'h0; wbe1_b = 8'h0F;
    step();
    we1_b = 1'b0;
    ra_b = {4'd15, 4'd15, 4'd15, 4'd15};
    #1;
    check_eq("wide_part_p0", rd_b[0   +: 64], 64'hFEDCBA9800000000);
    check_eq("wide_part_p2", rd_b[128 +: 64], 64'hFEDCBA9800000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
